// File: rtl/read_operands.sv
// Operand fetch engine: issues NUM_OPERANDS sequential reads from a base address and steers
// each latency-delayed return into its own slot. Optional macro: READ_OPERANDS_CLEAR_EN.
module read_operands #(
    parameter int unsigned SIZE_DATA    = 8,
    parameter int unsigned SIZE_ADDR    = 8,
    parameter int unsigned NUM_OPERANDS = 2,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [SIZE_ADDR-1:0]              i_base_addr,
    input  logic [SIZE_DATA-1:0]              i_data,
    output logic                              o_rd_en,
    output logic [SIZE_ADDR-1:0]              o_rd_addr,
    output logic [NUM_OPERANDS*SIZE_DATA-1:0] o_data,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int unsigned CntW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(NUM_OPERANDS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [SIZE_ADDR-1:0] base_q, base_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 rd_en_q, rd_en_d;
    logic [SIZE_ADDR-1:0] rd_addr_q, rd_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [CntW-1:0]      pipe_slot_q [RD_LATENCY];
    logic [CntW-1:0]      pipe_slot_d [RD_LATENCY];
    logic [SIZE_DATA-1:0] data_q [NUM_OPERANDS];
    logic [SIZE_DATA-1:0] data_d [NUM_OPERANDS];

    logic            accept;
    logic            ret_vld;
    logic [CntW-1:0] ret_slot;

    assign accept   = ((state_q == StIdle) || (state_q == StDone)) && i_start;
    assign ret_vld  = pipe_vld_q[RD_LATENCY-1];
    assign ret_slot = pipe_slot_q[RD_LATENCY-1];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StIssue;
                    base_d  = i_base_addr;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (cnt_q == LastIdx) begin
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (ret_vld && (ret_slot == LastIdx)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        rd_en_d   = (state_d == StIssue);
        rd_addr_d = rd_addr_q;
        if (state_d == StIssue) begin
            rd_addr_d = base_d + SIZE_ADDR'(cnt_d);
        end
        busy_d = (state_d == StIssue) || (state_d == StWait);
        done_d = (state_d == StDone);
    end

    // Return tracking and operand capture
    always_comb begin
        pipe_vld_d[0]  = rd_en_q;
        pipe_slot_d[0] = cnt_q;
        for (int j = 1; j < int'(RD_LATENCY); j++) begin
            pipe_vld_d[j]  = pipe_vld_q[j-1];
            pipe_slot_d[j] = pipe_slot_q[j-1];
        end
        for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
            data_d[k] = data_q[k];
`ifdef READ_OPERANDS_CLEAR_EN
            if (accept) begin
                data_d[k] = '0;
            end
`endif
            if (ret_vld && (ret_slot == CntW'(k))) begin
                data_d[k] = i_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_vld_q <= '0;
            for (int j = 0; j < int'(RD_LATENCY); j++) begin
                pipe_slot_q[j] <= '0;
            end
            for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pipe_vld_q <= pipe_vld_d;
            for (int j = 0; j < int'(RD_LATENCY); j++) begin
                pipe_slot_q[j] <= pipe_slot_d[j];
            end
            for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_OPERANDS); k++) begin : g_out
        assign o_data[k*SIZE_DATA +: SIZE_DATA] = data_q[k];
    end

    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = rd_addr_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_read_operands.sv
// Bench for read_operands: default (2 operands, latency 1) and wide (4 operands, latency 3)
// instances against a timing model derived from the fetch rules.
module tb_read_operands;

    localparam int N = 2;
    localparam int L = 1;

    logic        clk;
    logic        rst_n;
    logic        start, start4;
    logic [7:0]  base, base4;
    logic [7:0]  rdata, rdata4;
    logic        rd_en, rd_en4;
    logic [7:0]  rd_addr, rd_addr4;
    logic [15:0] odata;
    logic [31:0] odata4;
    logic        busy, busy4, done, done4;

    int tests = 0;
    int fails = 0;
    bit clear_en;
    logic [7:0] prev [N];
    logic [7:0] mem [256];

    read_operands #(.SIZE_DATA(8), .SIZE_ADDR(8), .NUM_OPERANDS(2), .RD_LATENCY(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base), .i_data(rdata),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_data(odata), .o_busy(busy), .o_done(done)
    );

    read_operands #(.SIZE_DATA(8), .SIZE_ADDR(8), .NUM_OPERANDS(4), .RD_LATENCY(3)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_base_addr(base4), .i_data(rdata4),
        .o_rd_en(rd_en4), .o_rd_addr(rd_addr4), .o_data(odata4), .o_busy(busy4),
        .o_done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with latency 1 and 3; junk data when nothing is returning.
    logic       m1_v;
    logic [7:0] m1_d;
    always @(posedge clk) begin
        m1_v <= rd_en;
        m1_d <= mem[rd_addr];
    end
    assign rdata = (m1_v === 1'b1) ? m1_d : 8'hEE;

    logic [2:0] m4_v;
    logic [7:0] m4_d [3];
    always @(posedge clk) begin
        m4_v    <= {m4_v[1:0], rd_en4};
        m4_d[0] <= mem[rd_addr4];
        m4_d[1] <= m4_d[0];
        m4_d[2] <= m4_d[1];
    end
    assign rdata4 = (m4_v[2] === 1'b1) ? m4_d[2] : 8'hEE;

    // One fetch on the default instance, checked every cycle from 1 to N+L+2.
    task automatic run_fetch(input logic [7:0] b);
        logic [7:0] nw [N];
        logic [7:0] ea, es;
        logic       exp_en;
        for (int k = 0; k < N; k++) nw[k] = mem[8'(b + k)];
        start = 1'b1;
        base  = b;
        @(posedge clk);
        #1 start = 1'b0;
        base = 8'($urandom);
        for (int c = 1; c <= N + L + 2; c++) begin
            @(negedge clk);
            exp_en = (c <= N);
            ea     = b + 8'(c - 1);
            tests++;
            if (rd_en !== exp_en) begin
                fails++;
                $display("FAIL rd_en base=%h cycle %0d: got %b want %b", b, c, rd_en, exp_en);
            end
            if (exp_en) begin
                tests++;
                if (rd_addr !== ea) begin
                    fails++;
                    $display("FAIL rd_addr base=%h cycle %0d: got %h want %h", b, c, rd_addr, ea);
                end
            end
            tests++;
            if (busy !== (c <= N + L)) begin
                fails++;
                $display("FAIL busy base=%h cycle %0d: got %b want %b", b, c, busy, c <= N + L);
            end
            tests++;
            if (done !== (c == N + L + 1)) begin
                fails++;
                $display("FAIL done base=%h cycle %0d: got %b want %b", b, c, done,
                         c == N + L + 1);
            end
            for (int k = 0; k < N; k++) begin
                // Slot k is issued in cycle k+1 and captured at the end of cycle k+1+L.
                es = (c > k + 1 + L) ? nw[k] : (clear_en ? 8'h00 : prev[k]);
                tests++;
                if (odata[k*8 +: 8] !== es) begin
                    fails++;
                    $display("FAIL slot%0d base=%h cycle %0d: got %h want %h", k, b, c,
                             odata[k*8 +: 8], es);
                end
            end
        end
        for (int k = 0; k < N; k++) prev[k] = nw[k];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        start4 = 1'b0;
        base   = 8'h00;
        base4  = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if ({rd_en, rd_addr, odata, busy, done} !== 27'd0) begin
            fails++;
            $display("FAIL reset_default: got %h want 0", {rd_en, rd_addr, odata, busy, done});
        end
        tests++;
        if ({rd_en4, rd_addr4, odata4, busy4, done4} !== 43'd0) begin
            fails++;
            $display("FAIL reset_wide: got %h want 0", {rd_en4, rd_addr4, odata4, busy4, done4});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({rd_en, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want 000", {rd_en, busy, done});
        end
        for (int k = 0; k < N; k++) prev[k] = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        for (int a = 0; a < 256; a++) mem[a] = 8'hA0 + 8'(a);
        run_fetch(8'h10);
        tests++;
        if (odata !== 16'hB1B0) begin
            fails++;
            $display("FAIL basic_data: got %h want b1b0", odata);
        end
    endtask

    task automatic test_wide;
        logic [7:0] addrs [4];
        logic [31:0] ed;
        addrs[0] = 8'hFE; addrs[1] = 8'hFF; addrs[2] = 8'h00; addrs[3] = 8'h01;
        for (int k = 0; k < 4; k++) mem[addrs[k]] = 8'($urandom);
        ed = {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]};
        start4 = 1'b1;
        base4  = 8'hFE;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            tests++;
            if (rd_en4 !== (c <= 4)) begin
                fails++;
                $display("FAIL wide_rd_en cycle %0d: got %b want %b", c, rd_en4, c <= 4);
            end
            if (c <= 4) begin
                tests++;
                if (rd_addr4 !== addrs[c-1]) begin
                    fails++;
                    $display("FAIL wide_addr cycle %0d: got %h want %h", c, rd_addr4, addrs[c-1]);
                end
            end
            tests++;
            if (busy4 !== (c <= 7) || done4 !== (c == 8)) begin
                fails++;
                $display("FAIL wide_busy_done cycle %0d: got %b%b want %b%b", c, busy4, done4,
                         c <= 7, c == 8);
            end
            if (c == 8) begin
                tests++;
                if (odata4 !== ed) begin
                    fails++;
                    $display("FAIL wide_data: got %h want %h", odata4, ed);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bases [13];
        logic [7:0] ea;
        logic [15:0] ed;
        int f, p;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        bases[0] = 8'($urandom);
        start = 1'b1;
        base  = bases[0];
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            // Keep wiggling the base so an ignored start with a fresh address would show up.
            if (e < 12) begin
                bases[e+1] = 8'($urandom);
                base       = bases[e+1];
            end
            if (e == 8) start = 1'b0;
            @(negedge clk);
            f = e / 4;
            p = e % 4;
            tests++;
            if (rd_en !== (f < 3 && p < 2)) begin
                fails++;
                $display("FAIL b2b_rd_en cycle %0d: got %b want %b", e + 1, rd_en, f < 3 && p < 2);
            end
            if (f < 3 && p < 2) begin
                ea = bases[4*f] + 8'(p);
                tests++;
                if (rd_addr !== ea) begin
                    fails++;
                    $display("FAIL b2b_addr cycle %0d: got %h want %h", e + 1, rd_addr, ea);
                end
            end
            tests++;
            if (done !== (f < 3 && p == 3)) begin
                fails++;
                $display("FAIL b2b_done cycle %0d: got %b want %b", e + 1, done, f < 3 && p == 3);
            end
            if (f < 3 && p == 3) begin
                ed = {mem[8'(bases[4*f] + 1)], mem[bases[4*f]]};
                tests++;
                if (odata !== ed) begin
                    fails++;
                    $display("FAIL b2b_data cycle %0d: got %h want %h", e + 1, odata, ed);
                end
            end
        end
        prev[0] = mem[bases[8]];
        prev[1] = mem[8'(bases[8] + 1)];
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            run_fetch(8'($urandom));
        end
    endtask

    task automatic test_clear_macro;
        mem[8'h40] = 8'h11;
        mem[8'h41] = 8'h22;
        run_fetch(8'h40);
        mem[8'h80] = 8'h33;
        mem[8'h81] = 8'h44;
        run_fetch(8'h80);
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        base  = 8'h20;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({rd_en, rd_addr, odata, busy, done} !== 27'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h want 0", {rd_en, rd_addr, odata, busy, done});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if ({rd_en, busy, done} !== 3'b000) begin
                fails++;
                $display("FAIL reset_mid_quiet cycle %0d: got %b want 000", c, {rd_en, busy, done});
            end
        end
        for (int k = 0; k < N; k++) prev[k] = 8'h00;
        @(posedge clk);
        #1;
        mem[8'h60] = 8'h5C;
        mem[8'h61] = 8'hC5;
        run_fetch(8'h60);
    endtask

    initial begin
`ifdef READ_OPERANDS_CLEAR_EN
        clear_en = 1'b1;
`else
        clear_en = 1'b0;
`endif
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_random();
        test_clear_macro();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/read_operands.md
# read_operands

Parametrised operand fetch engine for the datapath front-end. On a start pulse it issues `NUM_OPERANDS` consecutive single-word reads from a synchronous memory starting at a base address. It steers each returned word into its own operand slot, accounting for a configurable read latency, and flags completion with a one-cycle done pulse. It generalises the fixed two-operand reader: any operand count, addressed reads, latency-tolerant capture and a busy indication.

## Interface
- `SIZE_DATA`, 8, width of one data word / operand
- `SIZE_ADDR`, 8, memory address width
- `NUM_OPERANDS`, 2, operands fetched per start (≥1)
- `RD_LATENCY`, 1, cycles from `o_rd_en` high to valid `i_data` (≥1)
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_start`  in  1  request a fetch; sampled only when accepting (IDLE or DONE)
- `i_base_addr`  in  SIZE_ADDR  address of operand 0; sampled with accepted start
- `i_data`  in  SIZE_DATA  memory read data
- `o_rd_en`  out  1  memory read strobe
- `o_rd_addr`  out  SIZE_ADDR  memory read address
- `o_data`  out  NUM_OPERANDS*SIZE_DATA  operand k in bits [k*SIZE_DATA +: SIZE_DATA]
- `o_busy`  out  1  fetch in progress
- `o_done`  out  1  one-cycle pulse, all operands captured

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state IDLE.
- IDLE: if `i_start`, latch `i_base_addr`, clear issue counter, go to ISSUE.
- ISSUE: `o_rd_en`=1, `o_rd_addr` = base + k for k = 0..NUM_OPERANDS-1, one per cycle. After issue k = NUM_OPERANDS-1, go to WAIT.
- WAIT: hold until the last return is captured, then go to DONE.
- DONE: `o_done`=1 for exactly this cycle. If `i_start`=1, accept a new fetch and go to ISSUE; otherwise go to IDLE.
- Return tracking: a RD_LATENCY-deep shift pipeline carries (valid, slot index) for each issued read. When a valid entry emerges, `i_data` is written to that slot.
- Address arithmetic is modulo 2^SIZE_ADDR. Base + k wraps past all-ones to 0 with no error.
- `i_start` in ISSUE/WAIT is ignored; no queueing.
- `o_data` slots hold their value until overwritten by a later fetch (see Configuration).
- Reset values: `o_rd_en`=0, `o_rd_addr`=0, `o_data`=0, `o_busy`=0, `o_done`=0. Return pipeline and counters are cleared.
- Reset mid-fetch aborts immediately. No done pulse follows, and in-flight returns are discarded.

## Timing
- Start accepted at edge E0. `o_rd_en` is high in cycles 1..N (N = NUM_OPERANDS) and is registered, glitch-free.
- Read issued in cycle t: `i_data` is sampled at the end of cycle t+RD_LATENCY.
- `o_busy` is high in cycles 1..N+RD_LATENCY.
- `o_done` is high in cycle N+RD_LATENCY+1. All `o_data` slots are final and stable in that cycle.
- Total latency from start edge to done: N+RD_LATENCY+1 cycles. Default (2,1): done in cycle 4.
- Back-to-back: start held high in the DONE cycle puts the first `o_rd_en` of the next fetch in the following cycle. Throughput is one fetch per N+RD_LATENCY+1 cycles.

## Configuration
- `READ_OPERANDS_CLEAR_EN` defined: all `o_data` slots clear to 0 on the edge that accepts a start. Slots then fill individually as returns arrive.
- Not defined: slots keep previous-fetch values until each is individually overwritten.
- No other behaviour changes.

## Test plan
- Defaults: reset, base=0x10, start one cycle, memory returns 0xA0+addr at latency 1.
  - Required: `o_rd_en` in cycles 1–2 with addr 0x10, 0x11.
  - Required: done in cycle 4 with `o_data`={0xB1,0xB0} (slot1, slot0); busy cycles 1–3.
- NUM_OPERANDS=4, RD_LATENCY=3, base=0xFE: required addresses 0xFE, 0xFF, 0x00, 0x01; done in cycle 8; slots in issue order.
- Start held high continuously, defaults: fetches repeat every 4 cycles; exactly one done per fetch; starts during ISSUE/WAIT have no effect.
- Reset asserted in cycle 2 of a fetch:
  - Required: all outputs 0 immediately, no done.
  - Required: a new start after release gives a normal fetch with no stale capture.
- Macro on vs off: run fetch A (data 0x11,0x22), then fetch B. During B, slot 1 reads 0 in cycles 1–2 with the macro and 0x22 without; both read B's values at done.
